// File: rtl/shop_db.sv
// Small shop database: a user table with a fixed admin in slot 0 and an item
// table with quantities. Commands scan their whole table and then commit.
module shop_db #(
    parameter int MAX_USERS = 5,
    parameter int MAX_ITEMS = 8,
    parameter int A_W = 24,
    parameter int QTY_W = 8,
    parameter logic [A_W-1:0] ADMIN_NAME = "Adm"
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic                         i_rdy,
    input  logic [2:0]                   i_op,
    input  logic [A_W-1:0]               i_a,
    input  logic [QTY_W-1:0]             i_qty,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [2:0]                   o_status,
    output logic [A_W-1:0]               o_a,
    output logic                         o_logged,
    output logic [$clog2(MAX_USERS)-1:0] o_cur_u
);
    localparam int UW   = $clog2(MAX_USERS);
    localparam int TMAX = (MAX_USERS > MAX_ITEMS) ? MAX_USERS : MAX_ITEMS;
    localparam int CW   = $clog2(TMAX);

    localparam logic [2:0] OP_NONE = 3'd0, OP_LOGIN = 3'd1, OP_LOGOUT = 3'd2, OP_ADD_USER = 3'd3;
    localparam logic [2:0] OP_DEL_USER = 3'd4, OP_ADD_ITEM = 3'd5, OP_DEL_ITEM = 3'd6, OP_BUY = 3'd7;
    localparam logic [2:0] ST_OK = 3'd0, ST_DENIED = 3'd1, ST_NOT_FOUND = 3'd2, ST_FULL = 3'd3;
    localparam logic [2:0] ST_EXISTS = 3'd4, ST_INSUFF = 3'd5, ST_OVERFLOW = 3'd6;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_EXEC = 2'd2} state_t;

    function automatic logic [A_W-1:0] zext_qty(input logic [QTY_W-1:0] q);
        return {{(A_W-QTY_W){1'b0}}, q};
    endfunction

    state_t             state_r, state_nx_s;
    logic [2:0]         op_r;
    logic [A_W-1:0]     a_r;
    logic [QTY_W-1:0]   qty_r;
    logic [CW-1:0]      cnt_r, hit_idx_r, free_idx_r;
    logic               hit_r, free_r;
    logic               busy_r, done_r, logged_r;
    logic [2:0]         status_r;
    logic [A_W-1:0]     out_a_r;
    logic [UW-1:0]      cur_u_r;

    logic               user_valid_r [MAX_USERS];
    logic [A_W-1:0]     user_name_r  [MAX_USERS];
    logic               item_valid_r [MAX_ITEMS];
    logic [A_W-1:0]     item_name_r  [MAX_ITEMS];
    logic [QTY_W-1:0]   item_qty_r   [MAX_ITEMS];

    logic               user_op_s, last_s, ent_valid_s, match_s, free_s, admin_s;
    logic [A_W-1:0]     ent_name_s;
    logic [QTY_W-1:0]   hit_qty_s;
    logic [QTY_W:0]     sum_s;
    logic [2:0]         status_s;
    logic [A_W-1:0]     res_a_s;
    logic               u_wr_s, u_val_s, it_wr_s, it_val_s, login_s, logout_s;
    logic [CW-1:0]      u_idx_s, it_idx_s;
    logic [QTY_W-1:0]   it_qty_s;

    // Scan-entry selection: which table the current command walks, and where it ends.
    always_comb begin
        user_op_s   = (op_r == OP_LOGIN) || (op_r == OP_ADD_USER) || (op_r == OP_DEL_USER);
        ent_valid_s = 1'b0;
        ent_name_s  = '0;
        if (user_op_s) begin
            last_s = (cnt_r == CW'(MAX_USERS - 1));
            if (cnt_r < CW'(MAX_USERS)) begin
                ent_valid_s = user_valid_r[cnt_r];
                ent_name_s  = user_name_r[cnt_r];
            end else begin
                ent_valid_s = 1'b0;
            end
        end else begin
            last_s      = (cnt_r == CW'(MAX_ITEMS - 1));
            ent_valid_s = item_valid_r[cnt_r];
            ent_name_s  = item_name_r[cnt_r];
        end
        match_s = ent_valid_s && (ent_name_s == a_r);
        // Slot 0 belongs to the admin and is never handed out as a free user slot.
        free_s  = !ent_valid_s && !(user_op_s && (cnt_r == '0));
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (i_rdy) begin
                    state_nx_s = ((i_op == OP_NONE) || (i_op == OP_LOGOUT)) ? S_EXEC : S_SCAN;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_SCAN:  state_nx_s = last_s ? S_EXEC : S_SCAN;
            S_EXEC:  state_nx_s = S_IDLE;
            default: state_nx_s = S_IDLE;
        endcase
    end

    // Command decision made in EXEC from the scan results.
    always_comb begin
        admin_s   = logged_r && (cur_u_r == '0);
        hit_qty_s = item_qty_r[hit_idx_r];
        sum_s     = {1'b0, hit_qty_s} + {1'b0, qty_r};
        status_s  = ST_OK;
        res_a_s   = '0;
        u_wr_s    = 1'b0;
        u_val_s   = 1'b0;
        u_idx_s   = '0;
        it_wr_s   = 1'b0;
        it_val_s  = 1'b0;
        it_idx_s  = '0;
        it_qty_s  = '0;
        login_s   = 1'b0;
        logout_s  = 1'b0;
        case (op_r)
            OP_NONE: status_s = ST_OK;
            OP_LOGIN: begin
                if (logged_r)    status_s = ST_DENIED;
                else if (!hit_r) status_s = ST_NOT_FOUND;
                else begin
                    login_s = 1'b1;
                    res_a_s = a_r;
                end
            end
            OP_LOGOUT: begin
                if (!logged_r) status_s = ST_DENIED;
                else           logout_s = 1'b1;
            end
            OP_ADD_USER: begin
                if (!admin_s)     status_s = ST_DENIED;
                else if (hit_r)   status_s = ST_EXISTS;
                else if (!free_r) status_s = ST_FULL;
                else begin
                    u_wr_s  = 1'b1;
                    u_val_s = 1'b1;
                    u_idx_s = free_idx_r;
                    res_a_s = a_r;
                end
            end
            OP_DEL_USER: begin
                if (!admin_s || (a_r == ADMIN_NAME)) status_s = ST_DENIED;
                else if (!hit_r)                     status_s = ST_NOT_FOUND;
                else begin
                    u_wr_s  = 1'b1;
                    u_idx_s = hit_idx_r;
                end
            end
            OP_ADD_ITEM: begin
                if (!admin_s) status_s = ST_DENIED;
                else if (hit_r) begin
                    if (sum_s[QTY_W]) status_s = ST_OVERFLOW;
                    else begin
                        it_wr_s  = 1'b1;
                        it_val_s = 1'b1;
                        it_idx_s = hit_idx_r;
                        it_qty_s = sum_s[QTY_W-1:0];
                        res_a_s  = zext_qty(sum_s[QTY_W-1:0]);
                    end
                end else if (!free_r) status_s = ST_FULL;
                else begin
                    it_wr_s  = 1'b1;
                    it_val_s = 1'b1;
                    it_idx_s = free_idx_r;
                    it_qty_s = qty_r;
                    res_a_s  = zext_qty(qty_r);
                end
            end
            OP_DEL_ITEM: begin
                if (!admin_s)    status_s = ST_DENIED;
                else if (!hit_r) status_s = ST_NOT_FOUND;
                else begin
                    it_wr_s  = 1'b1;
                    it_idx_s = hit_idx_r;
                end
            end
            OP_BUY: begin
                if (!logged_r)            status_s = ST_DENIED;
                else if (!hit_r)          status_s = ST_NOT_FOUND;
                else if (qty_r > hit_qty_s) status_s = ST_INSUFF;
                else begin
                    it_wr_s  = 1'b1;
                    it_val_s = 1'b1;
                    it_idx_s = hit_idx_r;
                    it_qty_s = hit_qty_s - qty_r;
                    res_a_s  = zext_qty(hit_qty_s - qty_r);
                end
            end
            default: status_s = ST_OK;
        endcase
    end

    // Command capture and scan bookkeeping (lowest match, lowest free slot).
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            op_r       <= OP_NONE;
            a_r        <= '0;
            qty_r      <= '0;
            cnt_r      <= '0;
            hit_r      <= 1'b0;
            hit_idx_r  <= '0;
            free_r     <= 1'b0;
            free_idx_r <= '0;
        end else if ((state_r == S_IDLE) && i_rdy) begin
            op_r       <= i_op;
            a_r        <= i_a;
            qty_r      <= i_qty;
            cnt_r      <= '0;
            hit_r      <= 1'b0;
            hit_idx_r  <= '0;
            free_r     <= 1'b0;
            free_idx_r <= '0;
        end else if (state_r == S_SCAN) begin
            cnt_r <= cnt_r + 1'b1;
            if (match_s && !hit_r) begin
                hit_r     <= 1'b1;
                hit_idx_r <= cnt_r;
            end
            if (free_s && !free_r) begin
                free_r     <= 1'b1;
                free_idx_r <= cnt_r;
            end
        end
    end

    // Table storage; reset restores the admin-only, empty-shop state.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < MAX_USERS; i++) begin
                user_valid_r[i] <= (i == 0);
                user_name_r[i]  <= (i == 0) ? ADMIN_NAME : '0;
            end
            for (int j = 0; j < MAX_ITEMS; j++) begin
                item_valid_r[j] <= 1'b0;
                item_name_r[j]  <= '0;
                item_qty_r[j]   <= '0;
            end
        end else if (state_r == S_EXEC) begin
            if (u_wr_s) begin
                user_valid_r[u_idx_s] <= u_val_s;
                user_name_r[u_idx_s]  <= a_r;
            end
            if (it_wr_s) begin
                item_valid_r[it_idx_s] <= it_val_s;
                item_name_r[it_idx_s]  <= a_r;
                item_qty_r[it_idx_s]   <= it_qty_s;
            end
        end
    end

    // Registered status, session and handshake outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            status_r <= ST_OK;
            out_a_r  <= '0;
            logged_r <= 1'b0;
            cur_u_r  <= '0;
        end else begin
            busy_r <= (state_nx_s != S_IDLE);
            done_r <= (state_r == S_EXEC);
            if (state_r == S_EXEC) begin
                status_r <= status_s;
                out_a_r  <= res_a_s;
                if (login_s) begin
                    logged_r <= 1'b1;
                    cur_u_r  <= UW'(hit_idx_r);
                end else if (logout_s) begin
                    logged_r <= 1'b0;
                    cur_u_r  <= '0;
                end
            end
        end
    end

    assign o_busy   = busy_r;
    assign o_done   = done_r;
    assign o_status = status_r;
    assign o_a      = out_a_r;
    assign o_logged = logged_r;
    assign o_cur_u  = cur_u_r;
endmodule

// File: tb/tb_shop_db.sv
// Scoreboard bench for shop_db: directed commands push expected results,
// a negedge monitor pops and compares on every o_done pulse.
module tb_shop_db;
    localparam logic [2:0] NONE = 3'd0, LOGIN = 3'd1, LOGOUT = 3'd2, ADD_USER = 3'd3;
    localparam logic [2:0] DEL_USER = 3'd4, ADD_ITEM = 3'd5, DEL_ITEM = 3'd6, BUY = 3'd7;
    localparam logic [2:0] OK = 3'd0, DENIED = 3'd1, NOT_FOUND = 3'd2, FULL = 3'd3;
    localparam logic [2:0] EXISTS = 3'd4, INSUFF = 3'd5, OVERFLOW = 3'd6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_rdy = 1'b0;
    logic [2:0]  i_op = 3'd0;
    logic [23:0] i_a = 24'd0;
    logic [7:0]  i_qty = 8'd0;
    logic        o_busy, o_done, o_logged;
    logic [2:0]  o_status, o_cur_u;
    logic [23:0] o_a;

    typedef struct packed {
        logic [2:0]  st;
        logic [23:0] a;
        logic        ca;
        logic        lg;
        logic [2:0]  cu;
    } exp_t;
    exp_t sbq[$];

    int checks = 0;
    int errors = 0;

    shop_db dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_rdy(i_rdy), .i_op(i_op), .i_a(i_a), .i_qty(i_qty),
        .o_busy(o_busy), .o_done(o_done), .o_status(o_status), .o_a(o_a),
        .o_logged(o_logged), .o_cur_u(o_cur_u)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    // Monitor: every completion must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (o_done) begin
            exp_t e;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done status=%0d a=%0h want no completion", o_status, o_a);
            end else begin
                e = sbq.pop_front();
                chk("status", 32'(o_status), 32'(e.st));
                if (e.ca) chk("o_a", 32'(o_a), 32'(e.a));
                chk("logged", 32'(o_logged), 32'(e.lg));
                chk("cur_u", 32'(o_cur_u), 32'(e.cu));
                chk("busy_at_done", 32'(o_busy), 32'd0);
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [23:0] a, input logic [7:0] qty,
                         input logic [2:0] es, input logic [23:0] ea, input logic ca,
                         input logic el, input logic [2:0] ec, input logic glitch);
        int want;
        int lat;
        bit seen;
        exp_t e;
        if ((op == NONE) || (op == LOGOUT)) want = 1;
        else if ((op == LOGIN) || (op == ADD_USER) || (op == DEL_USER)) want = 6;
        else want = 9;
        @(negedge clk);
        i_rdy = 1'b1; i_op = op; i_a = a; i_qty = qty;
        @(posedge clk); #1;
        i_rdy = 1'b0; i_op = NONE; i_a = 24'd0; i_qty = 8'd0;
        e.st = es; e.a = ea; e.ca = ca; e.lg = el; e.cu = ec;
        sbq.push_back(e);
        seen = 1'b0;
        lat = 0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            if (glitch && c == 3) begin
                i_rdy = 1'b1; i_op = DEL_ITEM; i_a = a;
            end else begin
                i_rdy = 1'b0; i_op = NONE;
            end
            @(posedge clk); #1;
            if (o_done) begin
                seen = 1'b1;
                lat = c;
            end
        end
        i_rdy = 1'b0; i_op = NONE; i_a = 24'd0;
        checks++;
        if (!seen || lat != want) begin
            errors++;
            $display("FAIL latency op=%0d got=%0d want=%0d", op, lat, want);
            if (!seen && sbq.size() != 0) void'(sbq.pop_front());
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_status", 32'(o_status), 32'd0);
        chk("rst_a", 32'(o_a), 32'd0);
        chk("rst_logged", 32'(o_logged), 32'd0);
        chk("rst_cur_u", 32'(o_cur_u), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] nm;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs();
        @(negedge clk) rst_n = 1'b1;

        issue(LOGIN, "Adm", 8'd0, OK, "Adm", 1'b1, 1'b1, 3'd0, 1'b0);
        issue(NONE, 24'd0, 8'd0, OK, 24'd0, 1'b1, 1'b1, 3'd0, 1'b0);
        issue(ADD_ITEM, "Pen", 8'd250, OK, 24'd250, 1'b1, 1'b1, 3'd0, 1'b0);
        issue(ADD_ITEM, "Pen", 8'd10, OVERFLOW, 24'd0, 1'b1, 1'b1, 3'd0, 1'b0);
        issue(ADD_USER, "Bob", 8'd0, OK, "Bob", 1'b1, 1'b1, 3'd0, 1'b0);
        issue(LOGOUT, 24'd0, 8'd0, OK, 24'd0, 1'b1, 1'b0, 3'd0, 1'b0);
        issue(LOGOUT, 24'd0, 8'd0, DENIED, 24'd0, 1'b1, 1'b0, 3'd0, 1'b0);
        issue(BUY, "Pen", 8'd1, DENIED, 24'd0, 1'b1, 1'b0, 3'd0, 1'b0);
        issue(ADD_ITEM, "Pen", 8'd1, DENIED, 24'd0, 1'b1, 1'b0, 3'd0, 1'b0);
        issue(LOGIN, "Bob", 8'd0, OK, "Bob", 1'b1, 1'b1, 3'd1, 1'b0);
        issue(LOGIN, "Bob", 8'd0, DENIED, 24'd0, 1'b1, 1'b1, 3'd1, 1'b0);
        issue(BUY, "Pen", 8'd251, INSUFF, 24'd0, 1'b1, 1'b1, 3'd1, 1'b0);
        issue(BUY, "Pen", 8'd250, OK, 24'd0, 1'b1, 1'b1, 3'd1, 1'b0);
        issue(BUY, "Pen", 8'd0, OK, 24'd0, 1'b1, 1'b1, 3'd1, 1'b0);
        issue(DEL_ITEM, "Pen", 8'd0, DENIED, 24'd0, 1'b1, 1'b1, 3'd1, 1'b0);
        issue(ADD_USER, "Cy", 8'd0, DENIED, 24'd0, 1'b1, 1'b1, 3'd1, 1'b0);
        issue(LOGOUT, 24'd0, 8'd0, OK, 24'd0, 1'b1, 1'b0, 3'd0, 1'b0);
        issue(LOGIN, "Zed", 8'd0, NOT_FOUND, 24'd0, 1'b1, 1'b0, 3'd0, 1'b0);
        issue(LOGIN, "Adm", 8'd0, OK, "Adm", 1'b1, 1'b1, 3'd0, 1'b0);
        issue(ADD_USER, "Bob", 8'd0, EXISTS, 24'd0, 1'b1, 1'b1, 3'd0, 1'b0);
        issue(DEL_USER, "Bob", 8'd0, OK, 24'd0, 1'b1, 1'b1, 3'd0, 1'b0);
        issue(ADD_USER, "Ann", 8'd0, OK, "Ann", 1'b1, 1'b1, 3'd0, 1'b0);
        issue(ADD_USER, "Cy", 8'd0, OK, "Cy", 1'b1, 1'b1, 3'd0, 1'b0);
        issue(ADD_USER, "Dee", 8'd0, OK, "Dee", 1'b1, 1'b1, 3'd0, 1'b0);
        issue(ADD_USER, "Eve", 8'd0, OK, "Eve", 1'b1, 1'b1, 3'd0, 1'b0);
        issue(ADD_USER, "Fay", 8'd0, FULL, 24'd0, 1'b1, 1'b1, 3'd0, 1'b0);
        issue(DEL_USER, "Adm", 8'd0, DENIED, 24'd0, 1'b1, 1'b1, 3'd0, 1'b0);
        issue(DEL_USER, "Zed", 8'd0, NOT_FOUND, 24'd0, 1'b1, 1'b1, 3'd0, 1'b0);
        issue(DEL_ITEM, "Pen", 8'd0, OK, 24'd0, 1'b0, 1'b1, 3'd0, 1'b0);
        issue(BUY, "Pen", 8'd0, NOT_FOUND, 24'd0, 1'b1, 1'b1, 3'd0, 1'b0);

        // Fill every item slot; item k starts with quantity k.
        for (int k = 0; k < 8; k++) begin
            nm = 24'h493000 + 24'(k);
            issue(ADD_ITEM, nm, 8'(k), OK, 24'(k), 1'b1, 1'b1, 3'd0, 1'b0);
        end
        issue(ADD_ITEM, "Xyz", 8'd1, FULL, 24'd0, 1'b1, 1'b1, 3'd0, 1'b0);
        issue(ADD_ITEM, 24'h493003, 8'd5, OK, 24'd8, 1'b1, 1'b1, 3'd0, 1'b0);
        issue(ADD_ITEM, 24'h493007, 8'd249, OVERFLOW, 24'd0, 1'b1, 1'b1, 3'd0, 1'b0);
        issue(ADD_ITEM, 24'h493007, 8'd248, OK, 24'd255, 1'b1, 1'b1, 3'd0, 1'b0);

        // A strobe during the scan must neither restart nor queue a command.
        issue(ADD_ITEM, 24'h493000, 8'd1, OK, 24'd1, 1'b1, 1'b1, 3'd0, 1'b1);
        repeat (15) @(posedge clk);
        #1 chk("idle_after_glitch", 32'(o_busy), 32'd0);

        // Reset in the middle of an ADD_ITEM scan aborts it without completion.
        @(negedge clk);
        i_rdy = 1'b1; i_op = ADD_ITEM; i_a = 24'h493000; i_qty = 8'd9;
        @(posedge clk); #1;
        i_rdy = 1'b0; i_op = NONE; i_a = 24'd0; i_qty = 8'd0;
        chk("busy_in_scan", 32'(o_busy), 32'd1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs();
        repeat (12) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1 check_reset_outputs();

        issue(LOGIN, "Cy", 8'd0, NOT_FOUND, 24'd0, 1'b1, 1'b0, 3'd0, 1'b0);
        issue(LOGIN, "Adm", 8'd0, OK, "Adm", 1'b1, 1'b1, 3'd0, 1'b0);
        issue(ADD_ITEM, 24'h493000, 8'd4, OK, 24'd4, 1'b1, 1'b1, 3'd0, 1'b0);
        issue(BUY, 24'h493007, 8'd0, NOT_FOUND, 24'd0, 1'b1, 1'b1, 3'd0, 1'b0);

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
